// File: rtl/uart_rx_if.sv
// CPU-side register bus and serial line of the UART receiver, bundled for port hookup.
interface uart_rx_if;
  logic       rx;
  logic       writeEnable;
  logic       readEnable;
  logic [1:0] regSelect;
  logic [7:0] writeData;
  logic       irq;

  modport master (output rx, writeEnable, readEnable, regSelect, writeData, input irq);
  modport slave  (input rx, writeEnable, readEnable, regSelect, writeData, output irq);
endinterface

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: synchronises rx, samples mid-bit, and exposes
// RXDATA/STATUS/CTRL over an 8-bit CPU bus with a tristated read port.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  uart_rx_if.slave   bus,
  output wire  [7:0] Data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rxData_q, rxData_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             en_q, en_d;
  logic             ie_q, ie_d;
  logic             sync1_q, sync2_q, prev_q;

  logic       rxS;
  logic       fallEdge;
  logic       readClear;
  logic [7:0] readData;
  logic       unusedWriteBits;

  assign rxS       = sync2_q;
  assign fallEdge  = prev_q & ~rxS;
  assign readClear = bus.readEnable && (bus.regSelect == 2'b00);
  assign unusedWriteBits = ^bus.writeData[7:4];

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rxData_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rxData_q <= rxData_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
    end
  end

  // Bus side effects are applied first so that receiver-generated flag sets override them.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    rxData_d = rxData_q;
    valid_d  = valid_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    en_d     = en_q;
    ie_d     = ie_q;

    if (readClear) valid_d = 1'b0;
    if (bus.writeEnable && bus.regSelect == 2'b01) begin
      if (bus.writeData[2]) ferr_d = 1'b0;
      if (bus.writeData[3]) ovr_d  = 1'b0;
    end
    if (bus.writeEnable && bus.regSelect == 2'b10) begin
      en_d = bus.writeData[0];
      ie_d = bus.writeData[1];
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_q && fallEdge) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxS ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxS;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rxS) begin
            ferr_d = 1'b1;
          end else if (valid_q && !readClear) begin
            ovr_d = 1'b1;
          end else begin
            rxData_d = shift_q;
            valid_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    readData = 8'h00;
    case (bus.regSelect)
      2'b00:   readData = rxData_q;
      2'b01:   readData = {4'b0000, ovr_q, ferr_q, (state_q != IDLE), valid_q};
      2'b10:   readData = {6'b000000, ie_q, en_q};
      default: readData = 8'h00;
    endcase
  end

  assign Data    = bus.readEnable ? readData : 8'bz;
  assign bus.irq = valid_q & ie_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven on rx, register reads push expected
// values into a scoreboard queue, and a monitor compares Data whenever a read is presented.
module tb_uart_rx;

  localparam int BIT = 4;

  logic clk;
  logic reset;
  wire  [7:0] Data;

  int assertions = 0;
  int failures   = 0;

  logic [7:0] expQ[$];
  string      nameQ[$];

  uart_rx_if busIf ();

  uart_rx #(.CLKS_PER_BIT(BIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (busIf.slave),
    .Data (Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one 8N1 frame, bit edges aligned just after a rising clock edge.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
    @(posedge clk);
    #1 busIf.rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 busIf.rx = value[i];
      repeat (BIT) @(posedge clk);
    end
    #1 busIf.rx = stopBit;
    repeat (BIT) @(posedge clk);
    #1 busIf.rx = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [7:0] value);
    @(posedge clk);
    #1;
    busIf.writeEnable = 1'b1;
    busIf.regSelect   = sel;
    busIf.writeData   = value;
    @(posedge clk);
    #1 busIf.writeEnable = 1'b0;
  endtask

  // Issue a one-cycle register read and queue what the monitor must see on Data.
  task automatic checkOutput(input logic [1:0] sel, input logic [7:0] expected, input string name);
    @(posedge clk);
    #1;
    expQ.push_back(expected);
    nameQ.push_back(name);
    busIf.readEnable = 1'b1;
    busIf.regSelect  = sel;
    @(posedge clk);
    #1 busIf.readEnable = 1'b0;
  endtask

  task automatic checkIrq(input logic expected, input string name);
    assertions++;
    if (busIf.irq !== expected) begin
      failures++;
      $display("[TB] FAIL %s: irq=%b expected %b", name, busIf.irq, expected);
    end
  endtask

  // Monitor: compares Data on the falling edge of every cycle a read is presented.
  initial begin
    logic [7:0] exp;
    string      nm;
    forever begin
      @(negedge clk);
      if (busIf.readEnable === 1'b1) begin
        assertions++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_read: Data=%02h expected no read", Data);
        end else begin
          exp = expQ.pop_front();
          nm  = nameQ.pop_front();
          if (Data !== exp) begin
            failures++;
            $display("[TB] FAIL %s: Data=%02h expected %02h", nm, Data, exp);
          end
        end
      end
    end
  end

  initial begin
    int drain;
    reset             = 1'b1;
    busIf.rx          = 1'b1;
    busIf.writeEnable = 1'b0;
    busIf.readEnable  = 1'b0;
    busIf.regSelect   = 2'b00;
    busIf.writeData   = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] reset state");
    checkIrq(1'b0, "reset_irq");
    checkOutput(2'b01, 8'h00, "reset_status");
    checkOutput(2'b00, 8'h00, "reset_rxdata");
    checkOutput(2'b10, 8'h00, "reset_ctrl");
    checkOutput(2'b11, 8'h00, "reserved_reg");

    $display("[TB] test 1: receive 0xA5");
    writeReg(2'b10, 8'h01);
    checkOutput(2'b10, 8'h01, "ctrl_en");
    applyStimulus(8'hA5, 1'b1);
    checkOutput(2'b01, 8'h01, "t1_status_valid");
    checkOutput(2'b00, 8'hA5, "t1_rxdata");
    checkOutput(2'b01, 8'h00, "t1_status_cleared");

    $display("[TB] test 2: start-bit glitch");
    @(posedge clk);
    #1 busIf.rx = 1'b0;
    @(posedge clk);
    #1 busIf.rx = 1'b1;
    @(posedge clk);
    checkOutput(2'b01, 8'h02, "t2_busy_pulse");
    repeat (6) @(posedge clk);
    checkOutput(2'b01, 8'h00, "t2_status_idle");
    checkOutput(2'b00, 8'hA5, "t2_rxdata_kept");

    $display("[TB] test 3: framing error");
    applyStimulus(8'h3C, 1'b0);
    checkOutput(2'b01, 8'h04, "t3_ferr");
    checkOutput(2'b00, 8'hA5, "t3_rxdata_kept");
    writeReg(2'b01, 8'h04);
    checkOutput(2'b01, 8'h00, "t3_ferr_cleared");

    $display("[TB] test 4: overrun");
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    checkOutput(2'b01, 8'h09, "t4_status_ovr");
    checkOutput(2'b00, 8'h11, "t4_rxdata_first");
    writeReg(2'b01, 8'h08);
    checkOutput(2'b01, 8'h00, "t4_ovr_cleared");

    $display("[TB] test 5: interrupt and disable");
    writeReg(2'b10, 8'h03);
    applyStimulus(8'h7E, 1'b1);
    checkIrq(1'b1, "t5_irq_set");
    checkOutput(2'b00, 8'h7E, "t5_rxdata");
    checkIrq(1'b0, "t5_irq_cleared");
    writeReg(2'b10, 8'h00);
    applyStimulus(8'h55, 1'b1);
    checkOutput(2'b01, 8'h00, "t5_disabled_status");
    checkOutput(2'b00, 8'h7E, "t5_disabled_rxdata");

    $display("[TB] test 6: reset mid-frame");
    writeReg(2'b10, 8'h01);
    fork
      applyStimulus(8'h5A, 1'b1);
      begin
        repeat (25) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
      end
    join
    checkIrq(1'b0, "t6_irq_reset");
    checkOutput(2'b01, 8'h00, "t6_status_reset");
    checkOutput(2'b00, 8'h00, "t6_rxdata_reset");
    checkOutput(2'b10, 8'h00, "t6_ctrl_reset");
    writeReg(2'b10, 8'h01);
    applyStimulus(8'h5A, 1'b1);
    checkOutput(2'b01, 8'h01, "t6_status_valid");
    checkOutput(2'b00, 8'h5A, "t6_rxdata");

    drain = 0;
    while (expQ.size() != 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (expQ.size() != 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
